// File: rtl/io_pwr_seq_pkg.sv
// Shared types and constants for the IO-ring power sequencer.
package io_pwr_seq_pkg;

    // FSM states; the encoding is visible on the STATE port.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_QUAL  = 2'd1,
        ST_IE_ON = 2'd2,
        ST_RUN   = 2'd3
    } pwr_state_t;

    // Default cycles both supplies must stay good before the ring qualifies.
    localparam int DEF_STABLE_CYC = 16;
    // Default cycles between enabling input buffers and output drivers.
    localparam int DEF_STEP_CYC   = 8;

    // Counter width: clog2 of the larger interval, at least one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module io_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] stage;

    // Shift the asynchronous level through two flops; reset clears both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= 2'b00;
        end else begin
            stage <= {stage[0], d};
        end
    end

    assign q = stage[1];

endmodule

// File: rtl/io_pwr_seq.sv
// IO-ring power sequencer: qualifies both supplies, enables pad input
// buffers, then after a fixed step enables pad output drivers. Any supply
// loss with the ring enabled drops everything at once and latches FAULT.
module io_pwr_seq
    import io_pwr_seq_pkg::*;
#(
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int STEP_CYC   = DEF_STEP_CYC
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       VDD_OK,
    input  logic       DVDD_OK,
    input  logic       EN_REQ,
    output logic       IE,
    output logic       OE,
    output logic       READY,
    output logic       FAULT,
    output logic [1:0] STATE
);

    localparam int CW = cnt_width(STABLE_CYC, STEP_CYC);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] CNT_SAT     = '1;

    logic          vdd_sync;
    logic          dvdd_sync;
    logic          sup_ok;

    pwr_state_t    state;
    pwr_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          fault;
    logic          fault_next;
    logic          ie_next;
    logic          oe_next;
    logic          ready_next;

    io_sync2 u_sync_vdd (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (VDD_OK),
        .q     (vdd_sync)
    );

    io_sync2 u_sync_dvdd (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (DVDD_OK),
        .q     (dvdd_sync)
    );

    assign sup_ok  = vdd_sync & dvdd_sync;
    // Saturating increment: the counter holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // State, counter and sticky fault registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_OFF;
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            fault <= fault_next;
        end
    end

    // Next-state logic; supply loss is checked before EN_REQ so that a
    // coincident drop of both still records the fault.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fault_next = fault;
        case (state)
            ST_OFF: begin
                cnt_next = '0;
                if (!EN_REQ) begin
                    fault_next = 1'b0;
                end else if (sup_ok) begin
                    state_next = ST_QUAL;
                end
            end
            ST_QUAL: begin
                if (!EN_REQ) begin
                    state_next = ST_OFF;
                end else if (!sup_ok) begin
                    cnt_next = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = ST_IE_ON;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_IE_ON: begin
                if (!sup_ok) begin
                    state_next = ST_OFF;
                    fault_next = 1'b1;
                end else if (!EN_REQ) begin
                    state_next = ST_OFF;
                end else if (cnt == STEP_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_RUN: begin
                if (!sup_ok) begin
                    state_next = ST_OFF;
                    fault_next = 1'b1;
                end else if (!EN_REQ) begin
                    state_next = ST_OFF;
                end
            end
            default: begin
                state_next = ST_OFF;
                cnt_next   = '0;
            end
        endcase
        // Every state starts its interval from zero.
        if (state_next != state) begin
            cnt_next = '0;
        end
    end

    // Output decode from the next state so outputs move with STATE.
    always_comb begin
        ie_next    = 1'b0;
        oe_next    = 1'b0;
        ready_next = 1'b0;
        case (state_next)
            ST_IE_ON: ie_next = 1'b1;
            ST_RUN: begin
                ie_next    = 1'b1;
                oe_next    = 1'b1;
                ready_next = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered pad enables; reset drops them without waiting for a clock.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            IE    <= 1'b0;
            OE    <= 1'b0;
            READY <= 1'b0;
        end else begin
            IE    <= ie_next;
            OE    <= oe_next;
            READY <= ready_next;
        end
    end

    assign FAULT = fault;
    assign STATE = state;

endmodule
